// File: rtl/fifo_param_mem_if.sv
// Bus bundle for fifo_param_mem: push/pop requests, popped data and occupancy/status flags.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the FIFO.
interface fifo_param_mem_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 3
);
  // Handshake: write is taken on a posedge when !full, or when full and read is also
  // taken on that edge. read is taken on a posedge when !empty. valid_out is high for
  // exactly the cycle after a taken read, while data_out holds that popped word.
  // Requests that are not taken are dropped and never retried by the FIFO.
  logic                 write;
  logic                 read;
  logic [DATA_SIZE-1:0] data_in;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   fifo_count;
  logic [1:0]           error_out;

  modport master (
    output write, read, data_in,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, fifo_count, error_out
  );

  modport slave (
    input  write, read, data_in,
    output data_out, valid_out, full, empty, almost_full, almost_empty, fifo_count, error_out
  );
endinterface

// File: rtl/fifo_param_mem.sv
// Parametrised synchronous FIFO with internal pointers, occupancy count and threshold flags.
// Optional sticky overflow/underflow flags on error_out are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_param_mem #(
  parameter int DATA_SIZE       = 8,
  parameter int ADDR_SIZE       = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input logic              clk,
  input logic              reset,
  fifo_param_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_CNT = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AF_CNT   = (ADDR_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_SIZE:0] AE_CNT   = (ADDR_SIZE+1)'(ALMOST_EMPTY_TH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   count;
  logic [DATA_SIZE-1:0] data_out_q;
  logic                 valid_q;
  logic                 full_c;
  logic                 empty_c;
  logic                 wr_accept;
  logic                 rd_accept;

  assign full_c  = (count == FULL_CNT);
  assign empty_c = (count == '0);

  // A full FIFO still takes a write when the same edge pops, since that pop frees the slot.
  assign rd_accept = bus.read && !empty_c;
  assign wr_accept = bus.write && (!full_c || bus.read);

  // Storage is deliberately not reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= rd_accept;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (rd_accept) begin
        rd_ptr     <= rd_ptr + ADDR_SIZE'(1);
        data_out_q <= mem[rd_ptr];
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + (ADDR_SIZE+1)'(1);
        2'b01:   count <= count - (ADDR_SIZE+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic [1:0] error_q;

  // Sticky on the offending request itself, independent of whether anything was accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 2'b00;
    end else begin
      if (bus.write && !bus.read && full_c) begin
        error_q[1] <= 1'b1;
      end
      if (bus.read && empty_c) begin
        error_q[0] <= 1'b1;
      end
    end
  end

  assign bus.error_out = error_q;
`else
  assign bus.error_out = 2'b00;
`endif

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.fifo_count   = count;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);
endmodule

// File: tb/tb_fifo_param_mem.sv
// Self-checking bench for fifo_param_mem: a directed vector table, hand sequences for the
// full/empty/reset corners, and a randomized run against a queue-based reference model.
module tb_fifo_param_mem;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fifo_param_mem_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

  fifo_param_mem #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic [1:0]    m_err;

  function automatic void model_update(logic rst, logic w, logic r, logic [DW-1:0] d);
    int n;
    n = mq.size();
    if (rst) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 2'b00;
      return;
    end
`ifdef FIFO_ERR_FLAGS_EN
    if (w && !r && n == DEPTH) m_err[1] = 1'b1;
    if (r && n == 0)           m_err[0] = 1'b1;
`endif
    m_valid = 1'b0;
    if (r && n > 0) begin
      m_dout  = mq.pop_front();
      m_valid = 1'b1;
    end
    if (w && mq.size() < DEPTH) mq.push_back(d);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count",        32'(bus.fifo_count),   32'(n));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("full",         32'(bus.full),         32'(n == DEPTH));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF_TH));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE_TH));
    chk("valid_out",    32'(bus.valid_out),    32'(m_valid));
    chk("data_out",     32'(bus.data_out),     32'(m_dout));
    chk("error_out",    32'(bus.error_out),    32'(m_err));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
    reset        = rst;
    bus.write    = w;
    bus.read     = r;
    bus.data_in  = d;
    @(posedge clk);
    model_update(rst, w, r, d);
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    int            exp_count;
    logic          exp_valid;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [DW-1:0] base;
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = '0;
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 2'b00;
    base    = 8'hA1;

    // reset x2, write A1..A8, read 8 words back, one idle cycle
    for (int i = 0; i < 2; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00};
    for (int k = 0; k < 8; k++)
      vecs[2+k] = '{1'b0, 1'b1, 1'b0, base + DW'(k), k + 1, 1'b0, 8'h00};
    for (int k = 0; k < 8; k++)
      vecs[10+k] = '{1'b0, 1'b0, 1'b1, 8'h00, 7 - k, 1'b1, base + DW'(k)};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hA8};

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d);
      chk("tbl_count", 32'(bus.fifo_count),   32'(vecs[i].exp_count));
      chk("tbl_valid", 32'(bus.valid_out),    32'(vecs[i].exp_valid));
      chk("tbl_dout",  32'(bus.data_out),     32'(vecs[i].exp_dout));
      chk("tbl_full",  32'(bus.full),         32'(vecs[i].exp_count == DEPTH));
      chk("tbl_af",    32'(bus.almost_full),  32'(vecs[i].exp_count >= AF_TH));
      chk("tbl_ae",    32'(bus.almost_empty), 32'(vecs[i].exp_count <= AE_TH));
      chk("tbl_err",   32'(bus.error_out),    32'd0);
    end

    // overflow: fill, push FF while full, drain and confirm FF never appears
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 8'hB1 + DW'(k));
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    chk("ovf_count", 32'(bus.fifo_count), 32'd8);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_err1", 32'(bus.error_out[1]), 32'd1);
`else
    chk("ovf_err1", 32'(bus.error_out[1]), 32'd0);
`endif
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("ovf_drain", 32'(bus.data_out), 32'(8'hB1 + DW'(k)));
    end

    // underflow: read while empty, then write+read while empty, then pop
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf_valid", 32'(bus.valid_out), 32'd0);
    chk("udf_dout",  32'(bus.data_out),  32'(8'hB8));
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_err0", 32'(bus.error_out[0]), 32'd1);
`else
    chk("udf_err0", 32'(bus.error_out[0]), 32'd0);
`endif
    step(1'b0, 1'b1, 1'b1, 8'h5C);
    chk("wr_rd_empty_count", 32'(bus.fifo_count), 32'd1);
    chk("wr_rd_empty_valid", 32'(bus.valid_out),  32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pop_5c", 32'(bus.data_out), 32'(8'h5C));

    // simultaneous push/pop at full for 20 cycles, pointers wrap twice
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 8'hC0 + DW'(k));
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'h77);
      chk("full_rw_count", 32'(bus.fifo_count), 32'd8);
      chk("full_rw_dout",  32'(bus.data_out),   (k < 8) ? 32'(8'hC0 + DW'(k)) : 32'h77);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // reset mid-stream with a concurrent write
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 8'hD0 + DW'(k));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_empty", 32'(bus.empty),      32'd1);
    chk("rst_valid", 32'(bus.valid_out),  32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rst_nostore", 32'(bus.valid_out), 32'd0);

    // randomized phases with varying write/read bias
    for (int ph = 0; ph < 4; ph++) begin
      int wb;
      int rb;
      case (ph)
        0:       begin wb = 80; rb = 30; end
        1:       begin wb = 30; rb = 80; end
        2:       begin wb = 60; rb = 60; end
        default: begin wb = 90; rb = 90; end
      endcase
      for (int c = 0; c < 150; c++) begin
        step(($urandom_range(0, 79) == 0),
             ($urandom_range(0, 99) < wb),
             ($urandom_range(0, 99) < rb),
             DW'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
